writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage, directly downstream of memory access.
//  - Registers the MEM/WB bundle and forms the writeback value: load data or ALU result or link PC.
//  - Writes the architectural register file (x0 hardwired to 0).
//  - Provides two bypassed read ports for decode, a forwarding tap for execute, and a 64-bit retired-instruction counter.
// PARAMETERS
//  XLEN   32  datapath width
//  NREGS  32  architectural register count; index width = $clog2(NREGS)
//  CNT_W  64  width of retired-instruction counter
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst            in   1     reset, asynchronous, active-high
//  mw_valid       in   1     MEM/WB bundle valid this cycle
//  mw_opcode      in   7     instruction opcode (riscv_pkg OPCODE_* values)
//  mw_funct3      in   3     load width/sign select
//  mw_rd          in   5     destination register
//  mw_alu_result  in   XLEN  ALU result / effective address
//  mw_lmd         in   XLEN  aligned 32-bit word read by memory access (LMD)
//  mw_npc         in   XLEN  PC+4 of the instruction
//  flush          in   1     kill bundle being captured this cycle
//  rs1_addr       in   5     decode read port 1 address
//  rs2_addr       in   5     decode read port 2 address
//  rs1_data       out  XLEN  read data 1 (combinational, bypassed)
//  rs2_data       out  XLEN  read data 2 (combinational, bypassed)
//  wb_valid       out  1     registered stage holds a retiring instruction
//  wb_we          out  1     register write occurs this cycle
//  wb_rd          out  5     registered destination
//  wb_data        out  XLEN  registered writeback value (forwarding tap)
//  wb_misaligned  out  1     registered load was misaligned (write suppressed)
//  instret        out  CNT_W retired-instruction count
// BEHAVIOUR
//  Reset (async, rst=1):
//  - wb_valid, wb_we and wb_misaligned go to 0.
//  - wb_rd and wb_data go to 0; instret goes to 0.
//  - All NREGS registers go to 0.
//  - Reset mid-operation discards the held bundle; no write occurs.
//  Stage register (edge N):
//  - Captures the bundle when mw_valid && !flush.
//  - Otherwise wb_valid <= 0, which inserts a bubble.
//  - flush has priority over mw_valid.
//  Value select, computed before capture:
//  - LOAD: byte/half is selected from mw_lmd by alu_result[1:0].
//  - LOAD funct3 000 LB and 100 LBU: sign-/zero-extend 8 bits.
//  - LOAD funct3 001 LH and 101 LHU: sign-/zero-extend 16 bits.
//  - LOAD funct3 010 LW: full word.
//  - LOAD, other funct3: treated as LW.
//  - JAL/JALR: value is mw_npc.
//  - OP, OP_IMM, LUI, AUIPC: value is mw_alu_result.
//  - STORE, BRANCH and unknown opcodes: no register write, but they still retire.
//  Misalignment:
//  - LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, sets wb_misaligned.
//  - A misaligned load does not write, but still retires.
//  Write enable:
//  - wb_we = wb_valid && writes_rd && !wb_misaligned && wb_rd!=0.
//  - The register file is written at edge N+1, so total latency is 2 edges from bundle presentation.
//  Read ports:
//  - A read of x0 returns 0.
//  - If wb_we && rsX_addr==wb_rd, return wb_data (write-through bypass).
//  - Otherwise return the array contents.
//  Retired-instruction counter:
//  - instret increments by 1 at every edge where wb_valid=1.
//  - It wraps from 2^CNT_W-1 to 0.
//  Back-to-back:
//  - A new bundle every cycle is legal; there is no stall.
//  - Consecutive writes to the same rd: the younger wins.
// TESTING
//  T1 reset:
//  - Assert rst mid-run -> all outputs 0 immediately, instret=0.
//  - Every rs read returns 0.
//  T2 ALU write:
//  - OP, rd=5, alu=0x1234_5678 -> wb_we=1 one cycle later.
//  - rs1_addr=5 reads 0x1234_5678 that cycle (bypass) and afterwards (array).
//  T3 loads, mw_lmd=0x80FF_7F01:
//  - LB, addr=0x4 -> 0x0000_0001.
//  - LB, addr=0x6 -> 0xFFFF_FFFF.
//  - LBU, addr=0x7 -> 0x0000_0080.
//  - LH, addr=0x6 -> 0xFFFF_80FF.
//  - LHU, addr=0x4 -> 0x0000_7F01.
//  T4 misaligned:
//  - LW, addr=0x6, rd=7 -> wb_misaligned=1, wb_we=0, x7 unchanged.
//  - instret still increments.
//  T5 x0/no-write opcodes:
//  - OP rd=0 -> x0 reads 0.
//  - STORE/BRANCH with rd=9 -> x9 unchanged.
//  - JAL rd=1, npc=0x200 -> x1=0x200.
//  T6 flush/bubbles and count:
//  - Send 10 valid bundles, 3 of them flushed -> instret=7.
//  - Flushed bundles produce no writes.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load extract, register file with
// bypassed decode reads, forwarding tap and retired-instruction counter.
//
// Ports:
//   clk, rst
//     Clock. Asynchronous active-high reset.
//   mw_valid, mw_opcode, mw_funct3, mw_rd, mw_alu_result, mw_lmd, mw_npc
//     Incoming MEM/WB bundle.
//   flush
//     Kills the bundle being captured this cycle.
//   rs1_addr/rs1_data, rs2_addr/rs2_data
//     Combinational decode read ports, with write-through bypass.
//   wb_valid, wb_we, wb_rd, wb_data, wb_misaligned
//     Registered stage state. wb_data is the forwarding tap.
//   instret
//     Retired-instruction count.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mw_valid,
  input  logic [6:0]       mw_opcode,
  input  logic [2:0]       mw_funct3,
  input  logic [AW-1:0]    mw_rd,
  input  logic [XLEN-1:0]  mw_alu_result,
  input  logic [XLEN-1:0]  mw_lmd,
  input  logic [XLEN-1:0]  mw_npc,
  input  logic             flush,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [AW-1:0]    wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_misaligned,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ld_val;
  logic            ld_mis;
  logic [XLEN-1:0] nxt_val;
  logic            nxt_wr;
  logic            nxt_mis;
  logic            wb_wr;

  logic [XLEN-1:0] regs [NREGS];

  // Align the addressed byte/half down to bit 0.
  always_comb begin
    sh     = mw_lmd >> {mw_alu_result[1:0], 3'b000};
    ld_val = mw_lmd;
    ld_mis = 1'b0;
    unique case (mw_funct3)
      3'b000: ld_val = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b100: ld_val = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b001: begin
        ld_val = {{(XLEN-16){sh[15]}}, sh[15:0]};
        ld_mis = mw_alu_result[0];
      end
      3'b101: begin
        ld_val = {{(XLEN-16){1'b0}}, sh[15:0]};
        ld_mis = mw_alu_result[0];
      end
      default: begin
        ld_val = mw_lmd;
        ld_mis = |mw_alu_result[1:0];
      end
    endcase
  end

  always_comb begin
    nxt_val = mw_alu_result;
    nxt_wr  = 1'b0;
    nxt_mis = 1'b0;
    unique case (mw_opcode)
      OP_LOAD: begin
        nxt_val = ld_val;
        nxt_wr  = 1'b1;
        nxt_mis = ld_mis;
      end
      OP_JAL, OP_JALR: begin
        nxt_val = mw_npc;
        nxt_wr  = 1'b1;
      end
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: begin
        nxt_wr = 1'b1;
      end
      OP_STORE, OP_BRANCH: nxt_wr = 1'b0;
      default: nxt_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_wr         <= 1'b0;
      wb_misaligned <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      instret       <= '0;
    end else begin
      if (mw_valid && !flush) begin
        wb_valid      <= 1'b1;
        wb_wr         <= nxt_wr;
        wb_misaligned <= nxt_mis;
        wb_rd         <= mw_rd;
        wb_data       <= nxt_val;
      end else begin
        wb_valid      <= 1'b0;
        wb_wr         <= 1'b0;
        wb_misaligned <= 1'b0;
      end
      if (wb_valid)
        instret <= instret + 1'b1;
    end
  end

  assign wb_we = wb_valid && wb_wr && !wb_misaligned
              && (wb_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Write-through bypass so decode sees this cycle's write.
  always_comb begin
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (wb_we && rs1_addr == wb_rd)
      rs1_data = wb_data;
    else
      rs1_data = regs[rs1_addr];

    if (rs2_addr == '0)
      rs2_data = '0;
    else if (wb_we && rs2_addr == wb_rd)
      rs2_data = wb_data;
    else
      rs2_data = regs[rs2_addr];
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors, queue scoreboard
// with an independent negedge monitor on wb_valid.
module tb_writeback_stage;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;

  logic        clk = 0;
  logic        rst;
  logic        mw_valid;
  logic [6:0]  mw_opcode;
  logic [2:0]  mw_funct3;
  logic [4:0]  mw_rd;
  logic [31:0] mw_alu_result;
  logic [31:0] mw_lmd;
  logic [31:0] mw_npc;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_misaligned;
  logic [63:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  longint exp_cnt = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .mw_valid(mw_valid), .mw_opcode(mw_opcode),
    .mw_funct3(mw_funct3), .mw_rd(mw_rd),
    .mw_alu_result(mw_alu_result), .mw_lmd(mw_lmd),
    .mw_npc(mw_npc), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_misaligned(wb_misaligned),
    .instret(instret)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Monitor: pops one expectation per retiring instruction.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", 64'(wb_rd), 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_we", 64'(wb_we), 64'(e.we));
        chk("wb_misaligned", 64'(wb_misaligned), 64'(e.mis));
        if (e.we)
          chk("wb_data", 64'(wb_data), 64'(e.data));
      end
    end
  end

  task automatic send(input logic [6:0] op,
                      input logic [2:0] f3,
                      input logic [4:0] rd,
                      input logic [31:0] alu,
                      input logic [31:0] lmd,
                      input logic [31:0] npc,
                      input logic fl,
                      input logic e_we,
                      input logic e_mis,
                      input logic [31:0] e_data);
    exp_t e;
    @(posedge clk);
    #1;
    mw_valid      = 1'b1;
    mw_opcode     = op;
    mw_funct3     = f3;
    mw_rd         = rd;
    mw_alu_result = alu;
    mw_lmd        = lmd;
    mw_npc        = npc;
    flush         = fl;
    if (!fl) begin
      e.rd = rd; e.data = e_data;
      e.we = e_we; e.mis = e_mis;
      exp_q.push_back(e);
      exp_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      mw_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // Call during the low clock phase.
  task automatic rd_chk(input string nm,
                        input logic [4:0] a,
                        input logic [31:0] want);
    rs1_addr = a;
    rs2_addr = a;
    #1;
    chk({nm, "_rs1"}, 64'(rs1_data), 64'(want));
    chk({nm, "_rs2"}, 64'(rs2_data), 64'(want));
  endtask

  localparam logic [31:0] LMD = 32'h80FF_7F01;

  initial begin
    rst = 1; mw_valid = 0; flush = 0;
    mw_opcode = 0; mw_funct3 = 0; mw_rd = 0;
    mw_alu_result = 0; mw_lmd = 0; mw_npc = 0;
    rs1_addr = 0; rs2_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_instret", instret, 0);
    rd_chk("rst_x5", 5'd5, 0);
    rst = 0;

    // T2: ALU write, bypass then array
    send(OP, 3'b000, 5'd5, 32'h1234_5678, 0, 0, 0,
         1, 0, 32'h1234_5678);
    idle(1);
    @(negedge clk);
    chk("t2_we", 64'(wb_we), 1);
    rd_chk("t2_bypass", 5'd5, 32'h1234_5678);
    idle(1);
    @(negedge clk);
    rd_chk("t2_array", 5'd5, 32'h1234_5678);

    // T3: loads back-to-back
    send(LOAD, 3'b000, 5'd10, 32'h4, LMD, 0, 0, 1, 0, 32'h0000_0001);
    send(LOAD, 3'b000, 5'd11, 32'h6, LMD, 0, 0, 1, 0, 32'hFFFF_FFFF);
    send(LOAD, 3'b100, 5'd12, 32'h7, LMD, 0, 0, 1, 0, 32'h0000_0080);
    send(LOAD, 3'b001, 5'd13, 32'h6, LMD, 0, 0, 1, 0, 32'hFFFF_80FF);
    send(LOAD, 3'b101, 5'd14, 32'h4, LMD, 0, 0, 1, 0, 32'h0000_7F01);
    send(LOAD, 3'b010, 5'd15, 32'h8, LMD, 0, 0, 1, 0, LMD);
    idle(2);
    @(negedge clk);
    rd_chk("lb4", 5'd10, 32'h0000_0001);
    rd_chk("lb6", 5'd11, 32'hFFFF_FFFF);
    rd_chk("lbu7", 5'd12, 32'h0000_0080);
    rd_chk("lh6", 5'd13, 32'hFFFF_80FF);
    rd_chk("lhu4", 5'd14, 32'h0000_7F01);
    rd_chk("lw8", 5'd15, LMD);

    // T4: misaligned, younger-wins on same rd
    send(OP, 3'b000, 5'd7, 32'hAAAA_0007, 0, 0, 0, 1, 0, 32'hAAAA_0007);
    send(LOAD, 3'b010, 5'd7, 32'h6, LMD, 0, 0, 0, 1, 0);
    send(LOAD, 3'b001, 5'd8, 32'h5, LMD, 0, 0, 0, 1, 0);
    send(OP, 3'b000, 5'd6, 32'h1, 0, 0, 0, 1, 0, 32'h1);
    send(OP, 3'b000, 5'd6, 32'h2, 0, 0, 0, 1, 0, 32'h2);
    idle(2);
    @(negedge clk);
    rd_chk("t4_x7", 5'd7, 32'hAAAA_0007);
    rd_chk("t4_x8", 5'd8, 0);
    rd_chk("t4_young", 5'd6, 32'h2);
    chk("t4_instret", instret, 64'(exp_cnt));

    // T5: x0 and non-writing opcodes
    send(OP, 3'b000, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    rd_chk("t5_x0_byp", 5'd0, 0);
    send(OPIMM, 3'b000, 5'd9, 32'h99, 0, 0, 0, 1, 0, 32'h99);
    send(STORE, 3'b010, 5'd9, 32'h1111, 0, 0, 0, 0, 0, 0);
    send(BRANCH, 3'b000, 5'd9, 32'h2222, 0, 0, 0, 0, 0, 0);
    send(7'b1111111, 3'b000, 5'd9, 32'h3333, 0, 0, 0, 0, 0, 0);
    send(JAL, 3'b000, 5'd1, 32'h77, 0, 32'h200, 0, 1, 0, 32'h200);
    send(JALR, 3'b000, 5'd2, 32'h77, 0, 32'h304, 0, 1, 0, 32'h304);
    send(LUI, 3'b000, 5'd3, 32'h1234_5000, 0, 0, 0,
         1, 0, 32'h1234_5000);
    idle(2);
    @(negedge clk);
    rd_chk("t5_x0", 5'd0, 0);
    rd_chk("t5_x9", 5'd9, 32'h99);
    rd_chk("t5_jal", 5'd1, 32'h200);
    rd_chk("t5_jalr", 5'd2, 32'h304);
    rd_chk("t5_lui", 5'd3, 32'h1234_5000);
    chk("t5_instret", instret, 64'(exp_cnt));

    // T1: reset while a bundle is held
    send(OP, 3'b000, 5'd4, 32'h5, 0, 0, 0, 1, 0, 32'h5);
    @(posedge clk);
    #1;
    mw_valid = 0;
    rst = 1;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    chk("t1_valid", 64'(wb_valid), 0);
    chk("t1_we", 64'(wb_we), 0);
    chk("t1_rd", 64'(wb_rd), 0);
    chk("t1_data", 64'(wb_data), 0);
    chk("t1_mis", 64'(wb_misaligned), 0);
    chk("t1_instret", instret, 0);
    rd_chk("t1_x5", 5'd5, 0);
    rd_chk("t1_x1", 5'd1, 0);
    @(negedge clk);
    rst = 0;
    idle(2);
    @(negedge clk);
    rd_chk("t1_x4", 5'd4, 0);
    chk("t1_instret_hold", instret, 0);

    // T6: 10 bundles, 3 flushed
    for (int i = 0; i < 10; i++) begin
      logic fl;
      fl = (i == 2 || i == 5 || i == 8);
      send(OP, 3'b000, 5'(16 + i), 32'h100 + i, 0, 0, fl,
           1, 0, 32'h100 + i);
    end
    idle(2);
    @(negedge clk);
    chk("t6_instret", instret, 64'd7);
    rd_chk("t6_x16", 5'd16, 32'h100);
    rd_chk("t6_x18", 5'd18, 0);
    rd_chk("t6_x21", 5'd21, 0);
    rd_chk("t6_x24", 5'd24, 0);
    rd_chk("t6_x25", 5'd25, 32'h109);
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
